// File: rtl/button_events.sv
`default_nettype none
// ============================================================================
// Module      : button_events
// Description : Classifies a debounced button level into SHORT / LONG /
//               DOUBLE / REPEAT events behind a one-entry valid/ready buffer
//               with a sticky overflow flag. REPEAT events exist only when
//               the BUTTON_REPEAT_EN macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module button_events #(
    parameter int LONG_CYCLES   = 75000000,
    parameter int DBL_CYCLES    = 30000000,
    parameter int REPEAT_CYCLES = 15000000,
    parameter int CNT_W         = 27
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_level,
    output logic       ev_valid,
    output logic [1:0] ev_code,
    input  logic       ev_ready,
    output logic       ev_ovf,
    output logic       held
);

    localparam logic [1:0] c_EV_SHORT  = 2'd0;
    localparam logic [1:0] c_EV_LONG   = 2'd1;
    localparam logic [1:0] c_EV_DOUBLE = 2'd2;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_LONG_TC = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_DBL_TC  = CNT_W'(DBL_CYCLES - 1);

    localparam longint c_MAX_LD     = (LONG_CYCLES > DBL_CYCLES) ? longint'(LONG_CYCLES)
                                                                 : longint'(DBL_CYCLES);
    localparam longint c_MAX_CYCLES = (c_MAX_LD > longint'(REPEAT_CYCLES)) ? c_MAX_LD
                                                                           : longint'(REPEAT_CYCLES);

    generate
        if ((64'd1 << CNT_W) <= c_MAX_CYCLES) begin : g_cnt_w_too_small
            $error("button_events: CNT_W too small for the configured cycle counts");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRESS1    = 3'd1,
        S_LONG_HELD = 3'd2,
        S_WAIT2     = 3'd3,
        S_PRESS2    = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_in_d;
    logic             r_held;
    logic             r_ev_valid;
    logic [1:0]       r_ev_code;
    logic             r_ev_ovf;

    logic             w_rise;
    logic             w_fall;
    logic             w_emit;
    logic [1:0]       w_emit_code;
    logic             w_held_nxt;
    logic             w_accept;
    logic             w_drop;

    assign w_rise   = in_level & ~r_in_d;
    assign w_fall   = ~in_level & r_in_d;
    assign w_accept = r_ev_valid & ev_ready;
    assign w_drop   = w_emit & r_ev_valid & ~ev_ready;

    // Edges are tested before terminal counts so an edge wins a tie.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + c_CNT_ONE;
        w_emit      = 1'b0;
        w_emit_code = c_EV_SHORT;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_rise) begin
                    w_state_nxt = S_PRESS1;
                end
            end
            S_PRESS1: begin
                if (w_fall) begin
                    w_state_nxt = S_WAIT2;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_LONG_TC) begin
                    w_emit      = 1'b1;
                    w_emit_code = c_EV_LONG;
                    w_state_nxt = S_LONG_HELD;
                    w_cnt_nxt   = '0;
                end
            end
            S_LONG_HELD: begin
`ifdef BUTTON_REPEAT_EN
                if (w_fall) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_W'(REPEAT_CYCLES - 1)) begin
                    w_emit      = 1'b1;
                    w_emit_code = 2'd3;
                    w_cnt_nxt   = '0;
                end
`else
                w_cnt_nxt = '0;
                if (w_fall) begin
                    w_state_nxt = S_IDLE;
                end
`endif
            end
            S_WAIT2: begin
                if (w_rise) begin
                    w_emit      = 1'b1;
                    w_emit_code = c_EV_DOUBLE;
                    w_state_nxt = S_PRESS2;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_DBL_TC) begin
                    w_emit      = 1'b1;
                    w_emit_code = c_EV_SHORT;
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            S_PRESS2: begin
                w_cnt_nxt = '0;
                if (w_fall) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        w_held_nxt = (w_state_nxt == S_PRESS1) || (w_state_nxt == S_LONG_HELD) ||
                     (w_state_nxt == S_PRESS2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_in_d  <= 1'b0;
            r_held  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_in_d  <= in_level;
            r_held  <= w_held_nxt;
        end
    end

    // One-entry buffer: a coincident accept frees the slot for the new event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ev_valid <= 1'b0;
            r_ev_code  <= 2'd0;
            r_ev_ovf   <= 1'b0;
        end else begin
            if (w_emit && !w_drop) begin
                r_ev_valid <= 1'b1;
                r_ev_code  <= w_emit_code;
            end else if (w_accept) begin
                r_ev_valid <= 1'b0;
            end
            if (w_drop) begin
                r_ev_ovf <= 1'b1;
            end else if (w_accept) begin
                r_ev_ovf <= 1'b0;
            end
        end
    end

    assign ev_valid = r_ev_valid;
    assign ev_code  = r_ev_code;
    assign ev_ovf   = r_ev_ovf;
    assign held     = r_held;

endmodule
`default_nettype wire

// File: tb/tb_button_events.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_events
// Description : Directed self-checking bench for button_events with a
//               timestamp-based reference model (BUTTON_REPEAT_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_events;

    localparam int L = 20;
    localparam int D = 10;
    localparam int R = 5;
    localparam int W = 5;
`ifdef BUTTON_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       in_level = 1'b0;
    logic       ev_ready = 1'b1;
    logic       ev_valid;
    logic [1:0] ev_code;
    logic       ev_ovf;
    logic       held;

    button_events #(
        .LONG_CYCLES  (L),
        .DBL_CYCLES   (D),
        .REPEAT_CYCLES(R),
        .CNT_W        (W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_level(in_level),
        .ev_valid(ev_valid),
        .ev_code (ev_code),
        .ev_ready(ev_ready),
        .ev_ovf  (ev_ovf),
        .held    (held)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: phases with time stamps of the last phase entry.
    localparam int P_IDLE = 0, P_FIRST = 1, P_LONG = 2, P_GAP = 3, P_SECOND = 4;
    int         phase   = P_IDLE;
    int         t_enter = 0;
    bit         m_prev  = 1'b0;
    bit         m_valid = 1'b0;
    bit         m_ovf   = 1'b0;
    bit         m_held  = 1'b0;
    logic [1:0] m_code  = 2'd0;

    always @(posedge clk or negedge rst_n) begin
        bit rise, fall, emit, drop, acc;
        logic [1:0] code;
        if (!rst_n) begin
            phase = P_IDLE; t_enter = 0; m_prev = 1'b0;
            m_valid = 1'b0; m_ovf = 1'b0; m_held = 1'b0; m_code = 2'd0;
        end else begin
            cyc  = cyc + 1;
            rise = in_level && !m_prev;
            fall = !in_level && m_prev;
            m_prev = in_level;
            emit = 1'b0;
            code = 2'd0;
            case (phase)
                P_IDLE:   if (rise) begin phase = P_FIRST; t_enter = cyc; end
                P_FIRST:  if (fall) begin phase = P_GAP; t_enter = cyc; end
                          else if (cyc - t_enter == L) begin
                              emit = 1'b1; code = 2'd1; phase = P_LONG; t_enter = cyc;
                          end
                P_LONG:   if (fall) phase = P_IDLE;
                          else if (REP && (cyc - t_enter == R)) begin
                              emit = 1'b1; code = 2'd3; t_enter = cyc;
                          end
                P_GAP:    if (rise) begin emit = 1'b1; code = 2'd2; phase = P_SECOND; end
                          else if (cyc - t_enter == D) begin
                              emit = 1'b1; code = 2'd0; phase = P_IDLE;
                          end
                default:  if (fall) phase = P_IDLE;
            endcase
            acc  = m_valid && ev_ready;
            drop = emit && m_valid && !ev_ready;
            if (emit && !drop) begin m_valid = 1'b1; m_code = code; end
            else if (acc) m_valid = 1'b0;
            if (drop) m_ovf = 1'b1;
            else if (acc) m_ovf = 1'b0;
            m_held = (phase == P_FIRST) || (phase == P_LONG) || (phase == P_SECOND);
        end
    end

    int ev_t[$];
    int ev_c[$];
    int held_cnt = 0;

    always @(negedge clk) begin
        check("ev_valid", ev_valid, m_valid);
        check("ev_code",  ev_code,  m_code);
        check("ev_ovf",   ev_ovf,   m_ovf);
        check("held",     held,     m_held);
        if (rst_n && ev_valid && ev_ready) begin
            ev_t.push_back(cyc);
            ev_c.push_back(int'(ev_code));
        end
        if (held) held_cnt++;
    end

    task automatic clear_log();
        ev_t.delete();
        ev_c.delete();
        held_cnt = 0;
    endtask

    // Drive level for n cycles; t is the cycle in which the new level appears.
    task automatic lvl(input bit v, input int n, output int t);
        @(negedge clk);
        #1;
        in_level = v;
        t = cyc;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic check_first(input string nm, input int t_exp, input int c_exp);
        if (ev_t.size() > 0) begin
            check({nm, "_time"}, ev_t[0], t_exp);
            check({nm, "_code"}, ev_c[0], c_exp);
        end
    endtask

    initial begin
        int t, tr, n_exp;
        int exp_dt[4];
        int exp_cd[4];
        exp_dt = '{21, 26, 31, 36};
        exp_cd = '{1, 3, 3, 3};

        repeat (3) @(negedge clk);
        check("rst_valid", ev_valid, 0);
        check("rst_code",  ev_code,  0);
        check("rst_ovf",   ev_ovf,   0);
        check("rst_held",  held,     0);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Short press
        clear_log();
        lvl(1'b1, 5, t);
        lvl(1'b0, 30, tr);
        check("short_count", ev_t.size(), 1);
        check_first("short", tr + 11, 0);
        check("short_held", held_cnt, 5);

        // Double click
        clear_log();
        lvl(1'b1, 3, t);
        lvl(1'b0, 4, t);
        lvl(1'b1, 3, t);
        lvl(1'b0, 30, tr);
        check("dbl_count", ev_t.size(), 1);
        check_first("dbl", t + 1, 2);

        // Long hold, with repeats when enabled
        clear_log();
        lvl(1'b1, 37, t);
        lvl(1'b0, 30, tr);
        n_exp = REP ? 4 : 1;
        check("long_count", ev_t.size(), n_exp);
        for (int i = 0; i < n_exp; i++) begin
            if (i < ev_t.size()) begin
                check("long_time", ev_t[i], t + exp_dt[i]);
                check("long_code", ev_c[i], exp_cd[i]);
            end
        end
        check("long_held", held_cnt, 37);

        // Release exactly at the LONG terminal count
        clear_log();
        lvl(1'b1, 20, t);
        lvl(1'b0, 30, tr);
        check("bnd_count", ev_t.size(), 1);
        check_first("bnd", tr + 11, 0);

        // Backpressure: SHORT held, DOUBLE dropped
        @(negedge clk);
        #1 ev_ready = 1'b0;
        lvl(1'b1, 5, t);
        lvl(1'b0, 15, t);
        lvl(1'b1, 3, t);
        lvl(1'b0, 4, t);
        lvl(1'b1, 3, t);
        lvl(1'b0, 20, t);
        check("bp_valid", ev_valid, 1);
        check("bp_code",  ev_code,  0);
        check("bp_ovf",   ev_ovf,   1);
        repeat (5) @(negedge clk);
        check("bp_code_hold", ev_code, 0);
        check("bp_ovf_hold",  ev_ovf,  1);
        #1 ev_ready = 1'b1;
        @(negedge clk);
        check("bp_acc_valid", ev_valid, 0);
        check("bp_acc_ovf",   ev_ovf,   0);
        repeat (5) @(negedge clk);

        // Asynchronous reset in the middle of a press
        lvl(1'b1, 10, t);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", ev_valid, 0);
        check("mid_rst_code",  ev_code,  0);
        check("mid_rst_ovf",   ev_ovf,   0);
        check("mid_rst_held",  held,     0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        tr = cyc;
        clear_log();
        @(negedge clk);
        check("post_rst_held", held, 1);
        repeat (24) @(negedge clk);
        lvl(1'b0, 30, t);
        check_first("post_rst_long", tr + 21, 1);
        check("post_rst_any", (ev_t.size() > 0) ? 1 : 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
